// File: rtl/prf_wrb_pkg.sv
// Shared types for the writeback queue: the buffered result entry and pointer sizing.
// The optional same-cycle bypass is enabled with `define PRF_WRB_BYPASS_EN.
package prf_wrb_pkg;

  localparam int PRF_REG_SIZE_WIDTH  = 6;
  localparam int PRF_ROB_INDEX_WIDTH = 4;
  localparam int PRF_DATA_WIDTH      = 64;
  localparam int PRF_DEPTH           = 4;

  function automatic int depth_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEPTH_WIDTH = depth_width(PRF_DEPTH);

  typedef struct packed {
    logic [PRF_REG_SIZE_WIDTH-1:0]  prd;
    logic [PRF_DATA_WIDTH-1:0]      data;
    logic [PRF_ROB_INDEX_WIDTH-1:0] rob_index;
  } wrb_entry_t;

endpackage

// File: rtl/prf_wrb_fifo.sv
// One writeback channel: circular buffer with extra-MSB pointers, prd=0 masking and,
// when `define PRF_WRB_BYPASS_EN is set, an empty-FIFO input-to-output bypass.
module prf_wrb_fifo
  import prf_wrb_pkg::*;
#(
  parameter int DEPTH = PRF_DEPTH
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_flush,
  input  logic       i_valid,
  output logic       o_ready,
  input  wrb_entry_t i_entry,
  input  logic       i_rcu_ready,
  output logic       o_resp_valid,
  output wrb_entry_t o_entry
);

  localparam int DW = depth_width(DEPTH);

  logic [DW:0] r_wr_ptr;
  logic [DW:0] r_rd_ptr;
  wrb_entry_t  r_mem [DEPTH];

  logic       w_empty;
  logic       w_full;
  logic       w_head_valid;
  logic       w_bypass;
  logic       w_enq;
  logic       w_deq;
  logic       w_out_valid;
  wrb_entry_t w_sel;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[DW] != r_rd_ptr[DW]) &&
                        (r_wr_ptr[DW-1:0] == r_rd_ptr[DW-1:0]);
  assign o_ready      = !w_full && !i_flush;
  assign w_head_valid = !w_empty && !i_flush;

`ifdef PRF_WRB_BYPASS_EN
  assign w_bypass = w_empty && i_valid && i_rcu_ready && !i_flush;
  assign w_sel    = w_bypass ? i_entry : r_mem[r_rd_ptr[DW-1:0]];
`else
  assign w_bypass = 1'b0;
  assign w_sel    = r_mem[r_rd_ptr[DW-1:0]];
`endif

  // A bypassed result completes this cycle, so it must not also be written.
  assign w_enq        = i_valid && o_ready && !w_bypass;
  assign w_deq        = w_head_valid && i_rcu_ready;
  assign w_out_valid  = w_head_valid || w_bypass;
  assign o_resp_valid = w_out_valid && i_rcu_ready;

  // Fields are zero whenever nothing is presented; prd 0 also masks address and data.
  always_comb begin
    o_entry = '0;
    if (w_out_valid) begin
      o_entry.rob_index = w_sel.rob_index;
      if (w_sel.prd != '0) begin
        o_entry.prd  = w_sel.prd;
        o_entry.data = w_sel.data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + (DW+1)'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + (DW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) r_mem[r_wr_ptr[DW-1:0]] <= i_entry;
  end

endmodule

// File: rtl/prf_wrb_queue.sv
// Writeback buffering for the LSU and MD result streams: one prf_wrb_fifo per unit.
// Same-cycle bypass is compiled in with `define PRF_WRB_BYPASS_EN.
module prf_wrb_queue
  import prf_wrb_pkg::*;
#(
  parameter int REG_SIZE_WIDTH  = PRF_REG_SIZE_WIDTH,
  parameter int ROB_INDEX_WIDTH = PRF_ROB_INDEX_WIDTH,
  parameter int DEPTH           = PRF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush_i,
  input  logic                       lsu_result_valid_i,
  output logic                       lsu_result_ready_o,
  input  logic [REG_SIZE_WIDTH-1:0]  lsu_result_prd_i,
  input  logic [63:0]                lsu_result_data_i,
  input  logic [ROB_INDEX_WIDTH-1:0] lsu_result_rob_index_i,
  input  logic                       md_result_valid_i,
  output logic                       md_result_ready_o,
  input  logic [REG_SIZE_WIDTH-1:0]  md_result_prd_i,
  input  logic [63:0]                md_result_data_i,
  input  logic [ROB_INDEX_WIDTH-1:0] md_result_rob_index_i,
  input  logic                       lsu_rcu_ready_i,
  input  logic                       md_rcu_ready_i,
  output logic                       lsu_rcu_resp_valid_o,
  output logic                       md_rcu_resp_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]  lsu_wrb_address_o,
  output logic [REG_SIZE_WIDTH-1:0]  md_wrb_address_o,
  output logic [63:0]                lsu_wrb_data_o,
  output logic [63:0]                md_wrb_data_o,
  output logic [ROB_INDEX_WIDTH-1:0] lsu_wrb_rob_index_o,
  output logic [ROB_INDEX_WIDTH-1:0] md_wrb_rob_index_o
);

  wrb_entry_t w_lsu_in;
  wrb_entry_t w_lsu_out;
  wrb_entry_t w_md_in;
  wrb_entry_t w_md_out;

  assign w_lsu_in = '{lsu_result_prd_i, lsu_result_data_i, lsu_result_rob_index_i};
  assign w_md_in  = '{md_result_prd_i, md_result_data_i, md_result_rob_index_i};

  prf_wrb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_flush      (flush_i),
    .i_valid      (lsu_result_valid_i),
    .o_ready      (lsu_result_ready_o),
    .i_entry      (w_lsu_in),
    .i_rcu_ready  (lsu_rcu_ready_i),
    .o_resp_valid (lsu_rcu_resp_valid_o),
    .o_entry      (w_lsu_out)
  );

  prf_wrb_fifo #(.DEPTH(DEPTH)) u_md_fifo (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_flush      (flush_i),
    .i_valid      (md_result_valid_i),
    .o_ready      (md_result_ready_o),
    .i_entry      (w_md_in),
    .i_rcu_ready  (md_rcu_ready_i),
    .o_resp_valid (md_rcu_resp_valid_o),
    .o_entry      (w_md_out)
  );

  assign lsu_wrb_address_o   = w_lsu_out.prd;
  assign lsu_wrb_data_o      = w_lsu_out.data;
  assign lsu_wrb_rob_index_o = w_lsu_out.rob_index;
  assign md_wrb_address_o    = w_md_out.prd;
  assign md_wrb_data_o       = w_md_out.data;
  assign md_wrb_rob_index_o  = w_md_out.rob_index;

endmodule

// File: tb/tb_prf_wrb_queue.sv
// Directed and random-stream bench for prf_wrb_queue; latency checks follow
// `define PRF_WRB_BYPASS_EN when it is set for the build.
module tb_prf_wrb_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush_i;
  logic        lsu_result_valid_i, md_result_valid_i;
  logic        lsu_result_ready_o, md_result_ready_o;
  logic [5:0]  lsu_result_prd_i, md_result_prd_i;
  logic [63:0] lsu_result_data_i, md_result_data_i;
  logic [3:0]  lsu_result_rob_index_i, md_result_rob_index_i;
  logic        lsu_rcu_ready_i, md_rcu_ready_i;
  logic        lsu_rcu_resp_valid_o, md_rcu_resp_valid_o;
  logic [5:0]  lsu_wrb_address_o, md_wrb_address_o;
  logic [63:0] lsu_wrb_data_o, md_wrb_data_o;
  logic [3:0]  lsu_wrb_rob_index_o, md_wrb_rob_index_o;

  int errors = 0;
  int checks = 0;
  int lsu_done = 0;
  int md_done = 0;
  logic [73:0] lsu_q[$];
  logic [73:0] md_q[$];

  prf_wrb_queue dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .flush_i                (flush_i),
    .lsu_result_valid_i     (lsu_result_valid_i),
    .lsu_result_ready_o     (lsu_result_ready_o),
    .lsu_result_prd_i       (lsu_result_prd_i),
    .lsu_result_data_i      (lsu_result_data_i),
    .lsu_result_rob_index_i (lsu_result_rob_index_i),
    .md_result_valid_i      (md_result_valid_i),
    .md_result_ready_o      (md_result_ready_o),
    .md_result_prd_i        (md_result_prd_i),
    .md_result_data_i       (md_result_data_i),
    .md_result_rob_index_i  (md_result_rob_index_i),
    .lsu_rcu_ready_i        (lsu_rcu_ready_i),
    .md_rcu_ready_i         (md_rcu_ready_i),
    .lsu_rcu_resp_valid_o   (lsu_rcu_resp_valid_o),
    .md_rcu_resp_valid_o    (md_rcu_resp_valid_o),
    .lsu_wrb_address_o      (lsu_wrb_address_o),
    .md_wrb_address_o       (md_wrb_address_o),
    .lsu_wrb_data_o         (lsu_wrb_data_o),
    .md_wrb_data_o          (md_wrb_data_o),
    .lsu_wrb_rob_index_o    (lsu_wrb_rob_index_o),
    .md_wrb_rob_index_o     (md_wrb_rob_index_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [73:0] exp_of(input logic [5:0] prd, input logic [63:0] data,
                                         input logic [3:0] rob);
    if (prd == 6'd0) return {6'd0, 64'd0, rob};
    return {prd, data, rob};
  endfunction

  // Driver tasks
  task automatic set_lsu(input logic v, input logic [5:0] p, input logic [63:0] d,
                         input logic [3:0] r);
    lsu_result_valid_i     = v;
    lsu_result_prd_i       = p;
    lsu_result_data_i      = d;
    lsu_result_rob_index_i = r;
  endtask

  task automatic set_md(input logic v, input logic [5:0] p, input logic [63:0] d,
                        input logic [3:0] r);
    md_result_valid_i     = v;
    md_result_prd_i       = p;
    md_result_data_i      = d;
    md_result_rob_index_i = r;
  endtask

  // Scoreboard: push on accepted input, pop on each completion
  always @(negedge clk) begin
    if (!rstn || flush_i) begin
      if (rstn) begin
        chk("flush_lsu_valid", lsu_rcu_resp_valid_o, 0);
        chk("flush_md_valid", md_rcu_resp_valid_o, 0);
      end
      lsu_q.delete();
      md_q.delete();
    end else begin
      if (lsu_result_valid_i && lsu_result_ready_o)
        lsu_q.push_back(exp_of(lsu_result_prd_i, lsu_result_data_i, lsu_result_rob_index_i));
      if (md_result_valid_i && md_result_ready_o)
        md_q.push_back(exp_of(md_result_prd_i, md_result_data_i, md_result_rob_index_i));
      if (lsu_rcu_resp_valid_o) begin
        lsu_done++;
        if (lsu_q.size() == 0) chk("lsu_spurious_valid", lsu_rcu_resp_valid_o, 0);
        else chk("lsu_order", {lsu_wrb_address_o, lsu_wrb_data_o, lsu_wrb_rob_index_o},
                 lsu_q.pop_front());
      end
      if (md_rcu_resp_valid_o) begin
        md_done++;
        if (md_q.size() == 0) chk("md_spurious_valid", md_rcu_resp_valid_o, 0);
        else chk("md_order", {md_wrb_address_o, md_wrb_data_o, md_wrb_rob_index_o},
                 md_q.pop_front());
      end
    end
  end

  logic found;
  logic lsu_acc, md_acc;
  int   lsu_sent, md_sent, lsu_base, md_base;

  initial begin
    rstn = 1'b0;
    flush_i = 1'b0;
    lsu_rcu_ready_i = 1'b0;
    md_rcu_ready_i = 1'b0;
    set_lsu(0, 0, 0, 0);
    set_md(0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {lsu_rcu_resp_valid_o, md_rcu_resp_valid_o, lsu_wrb_address_o,
        md_wrb_address_o, lsu_wrb_data_o, md_wrb_data_o, lsu_wrb_rob_index_o,
        md_wrb_rob_index_o}, 0);
    rstn = 1'b1;
    #1;
    chk("reset_ready", {lsu_result_ready_o, md_result_ready_o}, 2'b11);

    // Single LSU result and its latency
    @(posedge clk); #1;
    lsu_rcu_ready_i = 1'b1;
    set_lsu(1, 6'd5, 64'hDEAD, 4'd3);
    @(negedge clk);
`ifdef PRF_WRB_BYPASS_EN
    chk("t1_bypass_same_cycle", {lsu_rcu_resp_valid_o, lsu_wrb_address_o, lsu_wrb_data_o,
        lsu_wrb_rob_index_o}, {1'b1, 6'd5, 64'hDEAD, 4'd3});
`else
    chk("t1_not_yet_valid", lsu_rcu_resp_valid_o, 0);
`endif
    @(posedge clk); #1;
    set_lsu(0, 0, 0, 0);
    @(negedge clk);
`ifdef PRF_WRB_BYPASS_EN
    chk("t1_no_repeat", lsu_rcu_resp_valid_o, 0);
`else
    chk("t1_next_cycle", {lsu_rcu_resp_valid_o, lsu_wrb_address_o, lsu_wrb_data_o,
        lsu_wrb_rob_index_o}, {1'b1, 6'd5, 64'hDEAD, 4'd3});
`endif

    // MD fills while the RCU stalls, then drains in order
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_md(1, 6'(10 + i), 64'h100 + 64'(i), 4'(i));
      @(negedge clk);
      chk("t2_ready_before_full", md_result_ready_o, 1);
    end
    @(posedge clk); #1;
    set_md(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_ready_full", md_result_ready_o, 0);
    chk("t2_stalled_valid", md_rcu_resp_valid_o, 0);
    chk("t2_head_fields", {md_wrb_address_o, md_wrb_data_o, md_wrb_rob_index_o},
        {6'd10, 64'h100, 4'd0});
    @(negedge clk);
    chk("t2_head_stable", {md_wrb_address_o, md_wrb_data_o}, {6'd10, 64'h100});
    @(posedge clk); #1;
    md_rcu_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_drain", {md_rcu_resp_valid_o, md_wrb_address_o}, {1'b1, 6'(10 + i)});
    end
    @(negedge clk);
    chk("t2_drained_empty", md_rcu_resp_valid_o, 0);

    // prd = 0 masks address and data but reports the ROB index
    @(posedge clk); #1;
    set_lsu(1, 6'd0, 64'hFFFF, 4'd7);
    found = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!found && lsu_rcu_resp_valid_o) begin
        found = 1'b1;
        chk("t3_prd0_fields", {lsu_wrb_address_o, lsu_wrb_data_o, lsu_wrb_rob_index_o},
            {6'd0, 64'd0, 4'd7});
      end
      @(posedge clk); #1;
      set_lsu(0, 0, 0, 0);
    end
    chk("t3_prd0_completed", found, 1);

    // Flush with two buffered entries and a concurrent input
    lsu_rcu_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_lsu(1, 6'(20 + i), 64'h200 + 64'(i), 4'(i));
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    set_lsu(1, 6'd22, 64'h222, 4'd2);
    @(negedge clk);
    chk("t4_flush_ready", lsu_result_ready_o, 0);
    chk("t4_flush_fields", {lsu_wrb_address_o, lsu_wrb_data_o}, 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    set_lsu(0, 0, 0, 0);
    lsu_rcu_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_after_flush_valid", lsu_rcu_resp_valid_o, 0);
    end

    // Reset while MD is 3/4 full
    md_rcu_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_md(1, 6'(30 + i), 64'h300 + 64'(i), 4'(8 + i));
    end
    @(posedge clk); #1;
    set_md(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_ready_3of4", md_result_ready_o, 1);
    chk("t5_head_before_reset", md_wrb_address_o, 6'd30);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("t5_reset_outputs", {lsu_rcu_resp_valid_o, md_rcu_resp_valid_o, lsu_wrb_address_o,
        md_wrb_address_o, lsu_wrb_data_o, md_wrb_data_o, lsu_wrb_rob_index_o,
        md_wrb_rob_index_o}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    md_rcu_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_ready_after_reset", md_result_ready_o, 1);
    chk("t5_empty_after_reset", md_rcu_resp_valid_o, 0);
    @(negedge clk);
    chk("t5_still_empty", md_rcu_resp_valid_o, 0);

    // Random-backpressure streams, 20 results per channel
    lsu_base = lsu_done;
    md_base  = md_done;
    lsu_sent = 0;
    md_sent  = 0;
    lsu_acc  = 1'b0;
    md_acc   = 1'b0;
    for (int cyc = 0; cyc < 2000 && (lsu_done - lsu_base < 20 || md_done - md_base < 20);
         cyc++) begin
      @(posedge clk); #1;
      if (lsu_acc) lsu_sent++;
      if (md_acc) md_sent++;
      lsu_rcu_ready_i = 1'($urandom_range(0, 1));
      md_rcu_ready_i  = 1'($urandom_range(0, 1));
      if (lsu_sent < 20 && $urandom_range(0, 3) != 0)
        set_lsu(1, 6'($urandom_range(0, 63)), {$urandom, $urandom}, 4'(lsu_sent));
      else
        set_lsu(0, 0, 0, 0);
      if (md_sent < 20 && $urandom_range(0, 3) != 0)
        set_md(1, 6'($urandom_range(0, 63)), {$urandom, $urandom}, 4'(md_sent));
      else
        set_md(0, 0, 0, 0);
      @(negedge clk);
      lsu_acc = lsu_result_valid_i && lsu_result_ready_o;
      md_acc  = md_result_valid_i && md_result_ready_o;
    end
    @(posedge clk); #1;
    set_lsu(0, 0, 0, 0);
    set_md(0, 0, 0, 0);
    lsu_rcu_ready_i = 1'b1;
    md_rcu_ready_i  = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_lsu_completions", lsu_done - lsu_base, 20);
    chk("t6_md_completions", md_done - md_base, 20);
    chk("t6_lsu_left_over", lsu_q.size(), 0);
    chk("t6_md_left_over", md_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prf_wrb_queue.md
# prf_wrb_queue

Writeback buffering stage between the variable-latency execution units (LSU, MD) and the physical register file write ports. Each unit hands results over a valid/ready handshake into a dedicated FIFO. Each FIFO drains at most one result per cycle onto its register-file write port and the RCU completion bus, under RCU backpressure. A flush discards all buffered results of squashed instructions.

## Interface
- `REG_SIZE_WIDTH`, 6, physical register address width
- `ROB_INDEX_WIDTH`, 4, ROB index width
- `DEPTH`, 4, entries per FIFO; power of two, at least 2
- `clk` in 1: clock, rising edge
- `rstn` in 1: reset, asynchronous, active-low
- `flush_i` in 1: squash; clears both FIFOs
- `lsu_result_valid_i` in 1 / `lsu_result_ready_o` out 1: LSU input handshake
- `lsu_result_prd_i` in REG_SIZE_WIDTH / `lsu_result_data_i` in 64 / `lsu_result_rob_index_i` in ROB_INDEX_WIDTH: LSU result
- `md_result_valid_i`, `md_result_ready_o`, `md_result_prd_i`, `md_result_data_i`, `md_result_rob_index_i`: same for MD
- `lsu_rcu_ready_i` in 1 / `md_rcu_ready_i` in 1: RCU accepts a completion this cycle
- `lsu_rcu_resp_valid_o` out 1 / `md_rcu_resp_valid_o` out 1: write-port and completion valid
- `lsu_wrb_address_o` / `md_wrb_address_o` out REG_SIZE_WIDTH: write address
- `lsu_wrb_data_o` / `md_wrb_data_o` out 64: write data
- `lsu_wrb_rob_index_o` / `md_wrb_rob_index_o` out ROB_INDEX_WIDTH: completing ROB entry

## Operation
- LSU and MD channels are identical and independent. The rules below apply to each channel.
- Enqueue: `valid_i & ready_o & !flush_i`. The entry {prd, data, rob_index} is written at the tail.
- `ready_o = !full & !flush_i`. The full flag comes from registered state only, never from the same-cycle dequeue.
- Output valid: `!empty & !flush_i`. Output fields come from the head entry.
- Dequeue: `resp_valid_o & rcu_ready_i`. The head advances on the edge.
- `resp_valid_o` is gated with `rcu_ready_i` before leaving the block. A register-file write therefore happens exactly once per completion, in the cycle the RCU accepts it.
- prd = 0: the entry still completes and the ROB index is reported. The address is driven as 0 and the data is driven as 64'b0.
- Pointers are DEPTH_WIDTH+1 bits and wrap naturally.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the rest of the bits are equal.
- Simultaneous enqueue and dequeue while full is impossible, because `ready_o` is 0.
- Simultaneous enqueue and dequeue while neither full nor empty leaves the occupancy unchanged.
- Flush: input is dropped in the flush cycle and the outputs are forced invalid. Both FIFOs are empty after the edge.
- Reset, including mid-operation: pointers are cleared and all buffered results are lost.
  - All valid outputs and address, data and ROB index outputs are 0.
  - `ready_o` reads 1 once `rstn` deasserts.
  - Entry storage is not reset.

## Timing
- Base latency: an enqueue at edge N appears on the outputs in cycle N+1.
- Throughput: one result per cycle per channel when `rcu_ready_i` is held at 1.
- A head stalled by `rcu_ready_i=0` holds all output fields stable until it is accepted.
- Flush has priority over enqueue, dequeue and bypass in the same cycle.

## Configuration
- `PRF_WRB_BYPASS_EN` defined: a bypass path applies when all of these hold in the same cycle:
  - the FIFO is empty;
  - `valid_i` is 1;
  - `rcu_ready_i` is 1;
  - `flush_i` is 0.
- When bypass applies, the input goes combinationally to the outputs, with the prd = 0 rule applied, and completes in that cycle. Nothing is enqueued and latency is 0.
- If `rcu_ready_i` is 0, the input enqueues as normal.
- Undefined: there is no combinational input-to-output path and latency is always 1 cycle or more.

## Structure
- Shared package `prf_wrb_pkg`: `wrb_entry_t` struct {prd, data, rob_index} and the DEPTH_WIDTH helper constant.
- One sub-module, `prf_wrb_fifo`: a single channel containing pointers, storage, flags and the bypass mux. It is instantiated once for LSU and once for MD.
- The top level is wiring only.

## Test plan
- Reset, then a single LSU result (prd=5, data=0xDEAD, rob=3) with `rcu_ready_i=1` -> cycle N+1 shows valid, address 5, data 0xDEAD, rob index 3. With bypass enabled the result appears in cycle N.
- `md_rcu_ready_i=0` while 4 MD results are sent -> `md_result_ready_o` drops after the 4th. Releasing ready -> the 4 results appear in order on 4 consecutive cycles.
- Result with prd=0 and data=0xFFFF -> completion with address 0 and data 0, and the ROB index is reported.
- 2 entries buffered, then `flush_i` pulsed for one cycle with a concurrent input -> no output in the flush cycle or after it, and the concurrent input is dropped.
- `rstn` asserted while the FIFO is 3/4 full -> all outputs go to 0 immediately, and after release the FIFO is empty with `ready_o=1`.
- Continuous LSU and MD streams of 20 results each with random `rcu_ready_i` -> per-channel order is preserved, no loss or duplication, and the pointers wrap correctly.
